reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises an async active-low reset, then releases NR_OUTPUTS resets in order.
// Optional software restart enabled by defining RESET_SEQ_SW_REQ_EN.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned NR_OUTPUTS     = 4,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STEP_CYCLES    = 8
) (
  input  logic                  clk,
  input  logic                  reset_in_,
  input  logic                  sw_reset_req,
  output logic [NR_OUTPUTS-1:0] reset_out_,
  output logic                  reset_done
);

  localparam int unsigned MAX_CYC = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IN_RESET, STRETCH, RELEASE, DONE} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NR_OUTPUTS-1:0]   out_q;
  logic                    done_q;
  logic [SYNC_STAGES-1:0]  sync_q;

  logic                    sync_rel;
  logic                    sw_req;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    stretch_hit;
  logic                    step_hit;
  logic [NR_OUTPUTS-1:0]   out_rel;
  logic                    last_rel;

`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_req = sw_reset_req;
`else
  logic unused_sw_req;
  assign unused_sw_req = sw_reset_req;
  assign sw_req        = 1'b0;
`endif

  // Release synchroniser; assertion is asynchronous, release ripples through the stages
  always_ff @(posedge clk or negedge reset_in_) begin
    if (!reset_in_) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rel    = sync_q[SYNC_STAGES-1];
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign stretch_hit = (cnt_inc == CNT_W'(STRETCH_CYCLES));
  assign step_hit    = (cnt_inc == CNT_W'(STEP_CYCLES));
  assign out_rel     = (out_q << 1) | NR_OUTPUTS'(1);
  assign last_rel    = &out_rel;

  // Sequencing FSM; the edge that first sees sync_rel counts as the first stretch cycle
  always_ff @(posedge clk or negedge reset_in_) begin
    if (!reset_in_) begin
      state_q <= IN_RESET;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else if (sw_req && (state_q == RELEASE || state_q == DONE)) begin
      state_q <= STRETCH;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IN_RESET, STRETCH: begin
          if (state_q == STRETCH || sync_rel) begin
            if (stretch_hit) begin
              cnt_q   <= '0;
              out_q   <= out_rel;
              done_q  <= last_rel;
              state_q <= last_rel ? DONE : RELEASE;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= STRETCH;
            end
          end
        end
        RELEASE: begin
          if (step_hit) begin
            cnt_q   <= '0;
            out_q   <= out_rel;
            done_q  <= last_rel;
            state_q <= last_rel ? DONE : RELEASE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DONE: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= IN_RESET;
          cnt_q   <= '0;
          out_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign reset_out_ = out_q;
  assign reset_done = done_q;

endmodule
